// File: rtl/bus_cycle_arbiter.sv
// bus_cycle_arbiter: two-requester round-robin arbiter that runs one
// multiplexed address/data bus cycle (T1, T2, T3, optional TW, T4) per grant.
// Optional feature: define BUS_CYCLE_ARBITER_WAIT_TIMEOUT_EN to bound the
// wait states at TIMEOUT cycles; an expired cycle completes with err.
module bus_cycle_arbiter #(
    parameter int unsigned ADDR_W  = 20,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clock,
    input  logic              resetb,
    input  logic [1:0]        req,
    input  logic [1:0]        rnw,
    input  logic [1:0]        io,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              ready,
    input  logic [DATA_W-1:0] bus_din,
    output logic [1:0]        gnt,
    output logic [1:0]        done,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic              ALE,
    output logic              rdb,
    output logic              wrb,
    output logic              IOM,
    output logic [ADDR_W-1:0] ad_out,
    output logic              ad_oe
);

    localparam logic [5:0] S_IDLE = 6'b000001;
    localparam logic [5:0] S_T1   = 6'b000010;
    localparam logic [5:0] S_T2   = 6'b000100;
    localparam logic [5:0] S_T3   = 6'b001000;
    localparam logic [5:0] S_TW   = 6'b010000;
    localparam logic [5:0] S_T4   = 6'b100000;

    // A zero limit would expire before the first wait state could be counted.
    if (TIMEOUT == 0) begin : g_timeout_check
        $error("bus_cycle_arbiter: TIMEOUT must be at least 1");
    end

    logic [5:0]        state;
    logic [5:0]        state_d;

    // Transaction latched on the IDLE->T1 edge.
    logic              sel;
    logic              last;
    logic              lat_rnw;
    logic              lat_io;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;

    logic              start;
    logic              pick;
    logic              cur_sel;
    logic              cur_rnw;
    logic              cur_io;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_wdata;

    logic              wait_expired;
    logic              capture;
    logic              busy_d;
    logic              in_strobe;
    logic              data_phase;

    logic              ale_d;
    logic              rdb_d;
    logic              wrb_d;
    logic              iom_d;
    logic              ad_oe_d;
    logic [ADDR_W-1:0] ad_out_d;
    logic [1:0]        gnt_d;
    logic [1:0]        done_d;

    // Next state, arbitration and next values of the registered bus outputs.
    always_comb begin
        state_d    = state;
        start      = 1'b0;
        // last=1 means requester 1 was served last, so requester 0 wins a tie.
        pick       = (req == 2'b10) || ((req == 2'b11) && !last);

        case (state)
            S_IDLE: begin
                if (|req) begin
                    state_d = S_T1;
                    start   = 1'b1;
                end
            end
            S_T1:    state_d = S_T2;
            S_T2:    state_d = S_T3;
            S_T3:    state_d = ready ? S_T4 : S_TW;
            S_TW: begin
                if (ready || wait_expired) begin
                    state_d = S_T4;
                end
            end
            S_T4:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // While starting, the outputs for T1 come straight from the winner's inputs.
        cur_sel    = start ? pick : sel;
        cur_rnw    = start ? rnw[pick] : lat_rnw;
        cur_io     = start ? io[pick] : lat_io;
        cur_addr   = start ? (pick ? addr1 : addr0) : lat_addr;
        cur_wdata  = start ? (pick ? wdata1 : wdata0) : lat_wdata;

        busy_d     = (state_d != S_IDLE);
        in_strobe  = (state_d == S_T2) || (state_d == S_T3) || (state_d == S_TW);
        data_phase = in_strobe || (state_d == S_T4);

        ale_d      = (state_d == S_T1);
        rdb_d      = !(in_strobe && cur_rnw);
        wrb_d      = !(in_strobe && !cur_rnw);
        iom_d      = busy_d && cur_io;
        ad_oe_d    = (state_d == S_T1) || (data_phase && !cur_rnw);
        ad_out_d   = '0;
        if (state_d == S_T1) begin
            ad_out_d = cur_addr;
        end else if (data_phase && !cur_rnw) begin
            ad_out_d = ADDR_W'(cur_wdata);
        end
        gnt_d      = busy_d ? {cur_sel, !cur_sel} : 2'b00;
        done_d     = (state_d == S_T4) ? {cur_sel, !cur_sel} : 2'b00;

        capture    = ((state == S_T3) || (state == S_TW)) && ready && lat_rnw;
    end

    // State register.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Latch the winning requester's transaction and update the round-robin pointer.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            sel       <= 1'b0;
            last      <= 1'b1;
            lat_rnw   <= 1'b0;
            lat_io    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (start) begin
            sel       <= pick;
            last      <= pick;
            lat_rnw   <= rnw[pick];
            lat_io    <= io[pick];
            lat_addr  <= pick ? addr1 : addr0;
            lat_wdata <= pick ? wdata1 : wdata0;
        end
    end

    // Registered bus strobes, grant and completion.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            ALE    <= 1'b0;
            rdb    <= 1'b1;
            wrb    <= 1'b1;
            IOM    <= 1'b0;
            ad_oe  <= 1'b0;
            ad_out <= '0;
            gnt    <= 2'b00;
            done   <= 2'b00;
        end else begin
            ALE    <= ale_d;
            rdb    <= rdb_d;
            wrb    <= wrb_d;
            IOM    <= iom_d;
            ad_oe  <= ad_oe_d;
            ad_out <= ad_out_d;
            gnt    <= gnt_d;
            done   <= done_d;
        end
    end

    // Read data captured on the edge that ends the strobe phase with ready.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            rdata <= '0;
        end else if (capture) begin
            rdata <= bus_din;
        end
    end

`ifdef BUS_CYCLE_ARBITER_WAIT_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] wait_cnt;

    assign wait_expired = (state == S_TW) && (wait_cnt == CNT_W'(TIMEOUT - 1));

    // Count wait states; cleared outside TW, on ready and on expiry.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            wait_cnt <= '0;
        end else if ((state == S_TW) && !ready && !wait_expired) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    // Timeout flag raised together with done when the wait limit forces T4.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            err <= 1'b0;
        end else begin
            err <= wait_expired && !ready;
        end
    end
`else
    assign wait_expired = 1'b0;
    assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_bus_cycle_arbiter.sv
// Randomized scoreboard bench for bus_cycle_arbiter, plus directed wait-limit
// and mid-cycle reset scenarios.
module tb_bus_cycle_arbiter;

    localparam int unsigned ADDR_W  = 20;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned N_TXN   = 30;
    localparam int          LIMIT   = 80;

    typedef struct packed {
        logic              rnw;
        logic              io;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } txn_t;

    typedef struct packed {
        logic [7:0]        w;
        logic [DATA_W-1:0] d;
    } slv_t;

    logic clock  = 1'b0;
    logic resetb = 1'b0;

    logic [1:0]        req, rnw, io;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              ready;
    logic [DATA_W-1:0] bus_din;
    logic [1:0]        gnt, done;
    logic              err;
    logic [DATA_W-1:0] rdata;
    logic              ALE, rdb, wrb, IOM;
    logic [ADDR_W-1:0] ad_out;
    logic              ad_oe;

    int errors = 0;
    int checks = 0;

    txn_t q0[$];
    txn_t q1[$];
    slv_t sq[$];

    logic              dir_mode  = 1'b0;
    logic              start_rnd = 1'b0;
    logic [1:0]        dir_req   = 2'b00;
    logic [1:0]        dir_rnw   = 2'b00;
    logic [1:0]        dir_io    = 2'b00;
    logic [ADDR_W-1:0] dir_addr0 = '0;
    logic [ADDR_W-1:0] dir_addr1 = '0;
    logic [DATA_W-1:0] dir_wd0   = '0;
    logic [DATA_W-1:0] dir_wd1   = '0;
    logic              dir_ready = 1'b0;
    logic [DATA_W-1:0] dir_din   = '0;
    logic              slv_ready = 1'b0;
    logic [DATA_W-1:0] slv_din   = '0;

    always #5 clock = ~clock;

    bus_cycle_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .resetb(resetb), .req(req), .rnw(rnw), .io(io),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ready(ready), .bus_din(bus_din), .gnt(gnt), .done(done), .err(err),
        .rdata(rdata), .ALE(ALE), .rdb(rdb), .wrb(wrb), .IOM(IOM),
        .ad_out(ad_out), .ad_oe(ad_oe)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // Two independent requesters issuing random transactions.
    for (genvar g = 0; g < 2; g++) begin : g_drv
        logic              rq  = 1'b0;
        logic              rw  = 1'b0;
        logic              ioq = 1'b0;
        logic [ADDR_W-1:0] a   = '0;
        logic [DATA_W-1:0] wd  = '0;
        logic              fin = 1'b0;
        initial begin
            txn_t t;
            int   cnt;
            int   gap;
            wait (start_rnd);
            for (int n = 0; n < int'(N_TXN); n++) begin
                t.rnw   = 1'($urandom);
                t.io    = 1'($urandom);
                t.addr  = ADDR_W'($urandom);
                t.wdata = DATA_W'($urandom);
                if (g == 0) q0.push_back(t); else q1.push_back(t);
                rw = t.rnw; ioq = t.io; a = t.addr; wd = t.wdata; rq = 1'b1;
                cnt = 0;
                do begin @(posedge clock); #1; cnt++; end while (!gnt[g] && cnt < LIMIT);
                chk($sformatf("drv%0d_grant_wait", g), 32'(gnt[g]), 32'd1);
                // Scramble inputs after the latch edge; they must be ignored.
                rw = 1'($urandom); ioq = 1'($urandom);
                a = ADDR_W'($urandom); wd = DATA_W'($urandom);
                if ($urandom_range(3) == 0) rq = 1'b0;
                cnt = 0;
                do begin @(posedge clock); #1; cnt++; end while (!done[g] && cnt < LIMIT);
                chk($sformatf("drv%0d_done_wait", g), 32'(done[g]), 32'd1);
                gap = int'($urandom_range(2));
                if (gap > 0) begin
                    rq = 1'b0;
                    repeat (gap) begin @(posedge clock); #1; end
                end
            end
            rq  = 1'b0;
            fin = 1'b1;
        end
    end

    assign req     = dir_mode ? dir_req   : {g_drv[1].rq,  g_drv[0].rq};
    assign rnw     = dir_mode ? dir_rnw   : {g_drv[1].rw,  g_drv[0].rw};
    assign io      = dir_mode ? dir_io    : {g_drv[1].ioq, g_drv[0].ioq};
    assign addr0   = dir_mode ? dir_addr0 : g_drv[0].a;
    assign addr1   = dir_mode ? dir_addr1 : g_drv[1].a;
    assign wdata0  = dir_mode ? dir_wd0   : g_drv[0].wd;
    assign wdata1  = dir_mode ? dir_wd1   : g_drv[1].wd;
    assign ready   = dir_mode ? dir_ready : slv_ready;
    assign bus_din = dir_mode ? dir_din   : slv_din;

    // Random slave: picks 0..3 wait states per cycle and records what it returns.
    int         k  = 0;
    logic [7:0] sw = 8'd0;
    always @(negedge clock) begin
        slv_din = DATA_W'($urandom);
        if (dir_mode || !resetb) begin
            k = 0;
            slv_ready = 1'b0;
        end else if (!rdb || !wrb) begin
            k++;
            if (k == 1) sw = 8'($urandom_range(3));
            slv_ready = (k >= 2 + int'(sw));
            if (slv_ready) sq.push_back('{sw, slv_din});
        end else begin
            k = 0;
            slv_ready = 1'($urandom);
        end
    end

    // Monitor: checks every cycle against the expected bus cycle shape.
    logic [1:0]        prev_req  = 2'b00;
    logic              last_r    = 1'b1;
    logic              act       = 1'b0;
    logic              gs        = 1'b0;
    logic [1:0]        eg;
    int                cyc       = 0;
    txn_t              cur;
    slv_t              sr;
    logic [DATA_W-1:0] exp_rdata = '0;

    always @(negedge clock) begin
        if (!resetb) begin
            act = 1'b0; last_r = 1'b1; prev_req = 2'b00; exp_rdata = '0;
        end else if (!dir_mode) begin
            if (ALE && !act) begin
                case (prev_req)
                    2'b01:   eg = 2'b01;
                    2'b10:   eg = 2'b10;
                    2'b11:   eg = last_r ? 2'b01 : 2'b10;
                    default: eg = 2'b00;
                endcase
                chk("grant", 32'(gnt), 32'(eg));
                if (eg != 2'b00) begin
                    gs = eg[1];
                    last_r = gs;
                    cur = '0;
                    if (gs && q1.size() > 0) cur = q1.pop_front();
                    else if (!gs && q0.size() > 0) cur = q0.pop_front();
                    chk("t1_addr", 32'(ad_out), 32'(cur.addr));
                    chk("t1_oe", 32'(ad_oe), 32'd1);
                    chk("t1_iom", 32'(IOM), 32'(cur.io));
                    chk("t1_strobes", 32'({rdb, wrb, done}), 32'(4'b1100));
                    act = 1'b1;
                    cyc = 1;
                end
            end else if (act) begin
                cyc++;
                chk("hold_gnt", 32'(gnt), gs ? 32'd2 : 32'd1);
                chk("hold_iom", 32'(IOM), 32'(cur.io));
                chk("hold_ale", 32'(ALE), 32'd0);
                if (done != 2'b00) begin
                    chk("done", 32'(done), gs ? 32'd2 : 32'd1);
                    chk("err", 32'(err), 32'd0);
                    chk("t4_strobes", 32'({rdb, wrb}), 32'd3);
                    chk("t4_oe", 32'(ad_oe), 32'(!cur.rnw));
                    if (!cur.rnw) chk("t4_wdata", 32'(ad_out), 32'(cur.wdata));
                    sr = '0;
                    if (sq.size() > 0) sr = sq.pop_front();
                    chk("cycle_len", 32'(cyc), 32'(4 + int'(sr.w)));
                    if (cur.rnw) exp_rdata = sr.d;
                    chk("rdata", 32'(rdata), 32'(exp_rdata));
                    act = 1'b0;
                end else begin
                    chk("rdb", 32'(rdb), 32'(!cur.rnw));
                    chk("wrb", 32'(wrb), 32'(cur.rnw));
                    chk("data_oe", 32'(ad_oe), 32'(!cur.rnw));
                    if (!cur.rnw) chk("data_wdata", 32'(ad_out), 32'(cur.wdata));
                    if (cyc > 12) begin
                        chk("cycle_overrun", 32'(cyc), 32'd12);
                        act = 1'b0;
                    end
                end
            end else begin
                chk("idle", 32'({ALE, rdb, wrb, IOM, ad_oe, gnt, done}), 32'(9'b011000000));
            end
            prev_req = req;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cnt;
        int  nlow;
        logic seen;

        // Reset state.
        repeat (3) @(posedge clock);
        #1;
        chk("rst_strobes", 32'({ALE, rdb, wrb, IOM, ad_oe}), 32'(5'b01100));
        chk("rst_gnt_done_err", 32'({gnt, done, err}), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_ad_out", 32'(ad_out), 32'd0);
        @(negedge clock);
        resetb = 1'b1;
        @(posedge clock); #1;

        // Random phase.
        start_rnd = 1'b1;
        cnt = 0;
        while (!(g_drv[0].fin && g_drv[1].fin) && cnt < 20000) begin
            @(posedge clock); #1; cnt++;
        end
        chk("rnd_finished", 32'(g_drv[0].fin && g_drv[1].fin), 32'd1);
        repeat (4) @(posedge clock);
        #1;
        chk("rnd_q_drained", 32'(q0.size() + q1.size() + sq.size()), 32'd0);
        dir_mode = 1'b1;
        @(posedge clock); #1;

        // Wait-state limit on a read with ready held low.
        dir_addr0 = 20'h12345; dir_rnw = 2'b01; dir_io = 2'b00;
        dir_ready = 1'b0; dir_din = 8'h5A; dir_req = 2'b01;
        cnt = 0;
        do begin @(posedge clock); #1; cnt++; end while (!ALE && cnt < 10);
        chk("to_ale", 32'(ALE), 32'd1);
        chk("to_addr", 32'(ad_out), 32'h12345);
        dir_req = 2'b00;
        seen = 1'b0;
        nlow = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(posedge clock); #1;
            if (done != 2'b00) seen = 1'b1;
            else if (!rdb) nlow++;
        end
`ifdef BUS_CYCLE_ARBITER_WAIT_TIMEOUT_EN
        chk("to_done_seen", 32'(seen), 32'd1);
        chk("to_low_cycles", 32'(nlow), 32'(2 + TIMEOUT));
        chk("to_done", 32'(done), 32'd1);
        chk("to_err", 32'(err), 32'd1);
        chk("to_rdata_kept", 32'(rdata), 32'(exp_rdata));
        @(posedge clock); #1;
        chk("to_pulse_end", 32'({err, done}), 32'd0);
`else
        chk("wait_no_done", 32'(seen), 32'd0);
        chk("wait_rdb_low", 32'(nlow), 32'd40);
        chk("wait_err", 32'(err), 32'd0);
        dir_ready = 1'b1;
        @(posedge clock); #1;
        chk("wait_release_done", 32'(done), 32'd1);
        chk("wait_release_rdata", 32'(rdata), 32'h5A);
        exp_rdata = 8'h5A;
        dir_ready = 1'b0;
        @(posedge clock); #1;
`endif
        @(posedge clock); #1;

        // Reset during T2 of an I/O write aborts the cycle.
        dir_wd1 = 8'hA5; dir_rnw = 2'b00; dir_io = 2'b10; dir_req = 2'b10;
        cnt = 0;
        do begin @(posedge clock); #1; cnt++; end while (!ALE && cnt < 10);
        chk("wr_gnt", 32'(gnt), 32'd2);
        chk("wr_iom", 32'(IOM), 32'd1);
        @(posedge clock); #1;
        chk("wr_t2_wrb", 32'(wrb), 32'd0);
        chk("wr_t2_data", 32'(ad_out), 32'h000A5);
        chk("wr_t2_oe", 32'(ad_oe), 32'd1);
        #2 resetb = 1'b0;
        #1;
        chk("abort_wrb", 32'(wrb), 32'd1);
        chk("abort_gnt", 32'(gnt), 32'd0);
        chk("abort_oe", 32'(ad_oe), 32'd0);
        chk("abort_rest", 32'({done, IOM, ALE}), 32'd0);
        dir_req = 2'b00;
        @(posedge clock);
        @(negedge clock);
        resetb = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clock); #1;
            chk("post_rst_idle", 32'({gnt, done, ALE, wrb, rdb}), 32'd3);
        end

        // After reset, simultaneous requests favour requester 0, then alternate.
        dir_rnw = 2'b11; dir_io = 2'b00; dir_ready = 1'b1; dir_req = 2'b11;
        for (int r = 0; r < 2; r++) begin
            cnt = 0;
            do begin @(posedge clock); #1; cnt++; end while (!ALE && cnt < 10);
            chk("rr_gnt", 32'(gnt), (r == 0) ? 32'd1 : 32'd2);
            if (r == 1) chk("rr_idle_gap", 32'(cnt), 32'd2);
            cnt = 0;
            do begin @(posedge clock); #1; cnt++; end while (done == 2'b00 && cnt < 10);
            chk("rr_done", 32'(done), (r == 0) ? 32'd1 : 32'd2);
            chk("rr_len", 32'(cnt), 32'd3);
        end
        dir_req = 2'b00;
        repeat (3) @(posedge clock);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_cycle_arbiter.md
BUS_CYCLE_ARBITER -- requirements
Module: bus_cycle_arbiter

Interface
REQ-001 Parameter ADDR_W, default 20, SHALL set the address width.
REQ-002 Parameter DATA_W, default 8, SHALL set the data width.
REQ-003 Parameter TIMEOUT, default 16, SHALL set the wait-state limit in cycles; it is used only with WAIT_TIMEOUT_EN.
REQ-004 clock  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 resetb  in  1  SHALL be the reset; it is asynchronous and active-low.
REQ-006 req  in  2  SHALL carry the bus request per requester, held high until that requester's done.
REQ-007 rnw  in  2  SHALL select read (1) or write (0) per requester.
REQ-008 io  in  2  SHALL select I/O (1) or memory (0) cycle per requester.
REQ-009 addr0, addr1  in  ADDR_W  SHALL carry the request address per requester.
REQ-010 wdata0, wdata1  in  DATA_W  SHALL carry the write data per requester.
REQ-011 ready  in  1  SHALL be the slave ready signal, sampled in T3/TW.
REQ-012 bus_din  in  DATA_W  SHALL be the read data from the bus.
REQ-013 gnt  out  2  SHALL be a one-hot grant, held from T1 through T4.
REQ-014 done  out  2  SHALL give a one-cycle completion pulse per requester.
REQ-015 err  out  1  SHALL give a one-cycle timeout pulse coincident with done.
REQ-016 rdata  out  DATA_W  SHALL hold the last captured read data.
REQ-017 ALE, rdb, wrb, IOM  out  1 each  SHALL be the bus strobes.
REQ-018 ad_out  out  ADDR_W  SHALL be the multiplexed address/data bus.
REQ-019 ad_oe  out  1  SHALL be the drive enable for ad_out.

Function
REQ-020 The FSM SHALL be one-hot with states IDLE, T1, T2, T3, TW, T4.
- IDLE->T1 when any req is high.
- T1->T2->T3 unconditionally.
- T3->T4 if ready=1, else T3->TW.
- TW->T4 when ready=1.
- T4->IDLE unconditionally.
REQ-021 The arbiter SHALL evaluate in IDLE.
- Single request: grant it.
- Both requests: grant the requester not served last (round-robin).
- The grant and the requester's rnw, io, addr and wdata are registered on the IDLE->T1 edge.
- Later changes to those inputs SHALL be ignored until T4.
REQ-022 Strobe and bus behaviour by state:
- ALE=1 only in T1.
- rdb=0 in T2, T3 and TW for reads.
- wrb=0 in T2, T3 and TW for writes.
- IOM equals the latched io from T1 to T4.
- ad_out carries the address in T1 and the zero-extended wdata in T2 to T4 for writes.
- ad_oe=1 in T1, and in T2 to T4 only for writes.
REQ-023 On a read, rdata SHALL capture bus_din on the edge leaving T3 or TW with ready=1.
REQ-024 done[g] SHALL be high for exactly the T4 cycle, and gnt SHALL clear on T4->IDLE.
REQ-025 Minimum cycle length SHALL be 4 clocks (T1 to T4), plus one clock per TW cycle.
REQ-026 A requester that keeps req high after done SHALL be re-granted next IDLE only if the other requester is idle.
REQ-027 A req deasserted mid-cycle SHALL NOT abort the cycle.
REQ-028 With no request, the block SHALL stay in IDLE with all strobes inactive.

Reset
REQ-029 While resetb=0, the block SHALL asynchronously force these values:
- state=IDLE, ALE=0, rdb=1, wrb=1, IOM=0.
- ad_out=0, ad_oe=0, gnt=0, done=0, err=0, rdata=0.
- Round-robin pointer favours requester 0.
REQ-030 Reset asserted mid-cycle SHALL abort the cycle without a done pulse, and strobes SHALL go inactive immediately.

Configuration
REQ-031 Macro BUS_CYCLE_ARBITER_WAIT_TIMEOUT_EN SHALL control the wait-state timeout.
- Defined: a counter SHALL count cycles spent in TW. When it reaches TIMEOUT with ready=0, the FSM SHALL go TW->T4, pulse done and err, leave rdata unchanged, and reset the counter.
- Undefined: TW SHALL wait indefinitely, and err SHALL be tied 0.

Verification
REQ-032 req=01, rnw=01, addr0=0x12345, ready=1 -> ALE in cycle 1 with ad_out=0x12345; rdb low in cycles 2-3; done=01 in cycle 4; rdata=bus_din sampled in cycle 3.
REQ-033 req=10, rnw=00, wdata1=0xA5, io=10 -> IOM=1 for T1 to T4; wrb low in T2-T3; ad_out=0x000A5 with ad_oe=1 in T2 to T4; done=10.
REQ-034 req=11 held continuously -> grants alternate 01, 10, 01, 10, with each cycle 4 clocks plus one IDLE cycle between.
REQ-035 Read with ready=0 for 3 cycles -> 3 TW cycles, rdb held low, done after 7 cycles, rdata captured on the edge ready returns high.
REQ-036 With the macro defined and TIMEOUT=16, ready held 0 -> exactly 16 TW cycles, then T4 with done and err=1 and rdata unchanged; with the macro undefined -> remains in TW.
REQ-037 resetb pulsed low during T2 of a write -> wrb=1, gnt=0 and ad_oe=0 immediately, no done pulse, and state IDLE after release.
